wb_irq_ctrl: RTL and testbench
==============================

Name: wb_irq_ctrl

Overview:
Wishbone-slave interrupt controller between the raw interrupt sources and the cpu interrupt input. Sources include debounced push-buttons, timer tick, UART received and address exception. It latches edge events and tracks levels, then masks them. It arbitrates by fixed priority (lowest index wins) and drives one registered irq line. Software uses a claim/complete handshake that removes an in-service source from arbitration until it is completed.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..31)
DW, 32, Wishbone data width
AW, 32, Wishbone address width

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
irq_src_i  input  NUM_SRC  interrupt sources, synchronous to clk
wb_adr_i  input  AW  byte address; only [4:2] decoded
wb_dat_i  input  DW  write data
wb_sel_i  input  4  byte selects (only all-ones accepted for writes)
wb_we_i  input  1  write enable
wb_stb_i  input  1  strobe
wb_cyc_i  input  1  cycle
wb_dat_o  output  DW  read data
wb_ack_o  output  1  transfer acknowledge
wb_err_o  output  1  error (unmapped or partial write)
wb_rty_o  output  1  tied 0
irq_o  output  1  interrupt request to cpu
irq_id_o  output  5  index of current highest-priority request (valid when irq_o=1)

Behaviour:
- Reset: when rst_n=0 at a clk edge, the following are cleared to 0: PENDING, ENABLE, EDGE, INSERV, src_q, the FSM (goes to IDLE), wb_dat_o, wb_ack_o, wb_err_o, irq_o and irq_id_o.
- Reset mid-transfer: the bus cycle is dropped with no ack.
- Register map (word offsets):
  - 0x00 STATUS: RO, PENDING & ENABLE & ~INSERV.
  - 0x04 PENDING: R; write-1-to-clear, edge sources only.
  - 0x08 ENABLE: RW.
  - 0x0C EDGE: RW; 1 = rising-edge source, 0 = level source.
  - 0x10 CLAIM: R; returns {valid[31], id[4:0]}.
  - 0x14 COMPLETE: W; id in [4:0].
  - 0x18 and 0x1C are unmapped and return err.
  - Bits at or above NUM_SRC read 0 and ignore writes.
- Source capture, per edge source i: src_q registers irq_src_i every cycle. The condition irq_src_i & ~src_q sets PENDING[i] at that edge.
- Source capture, per level source i: PENDING[i] <= irq_src_i each cycle, and W1C has no effect.
- Simultaneous event: an edge set and a W1C on the same bit in the same cycle leaves the set winning (bit stays 1).
- Arbitration: req = PENDING & ENABLE & ~INSERV. The winner is the lowest set index.
  - irq_o <= |req and irq_id_o <= winner are registered, one cycle after req changes.
  - Total latency from an edge on irq_src_i to irq_o = 2 clk edges.
- Bus FSM, states IDLE and RESP:
  - IDLE → RESP when wb_cyc_i & wb_stb_i. The register action, wb_dat_o and either ack or err (exactly one) are registered on this edge.
  - RESP → IDLE unconditionally. ack/err is a 1-cycle pulse.
  - Back-to-back transfers are therefore at most one per 2 cycles. A strobe held through RESP is not re-accepted until IDLE.
- CLAIM read, req ≠ 0: returns valid=1, id=winner. In the same edge INSERV[winner] is set, and PENDING[winner] is cleared if that source is an edge source.
- CLAIM read, req = 0: returns 0 with no state change.
- The claim snapshot uses req as registered at the accept edge. A source arriving in the same cycle is not claimable until the next cycle.
- COMPLETE write: clears INSERV[id] when id < NUM_SRC. Any other id is ignored, and the transfer still acks.
- A level source that is still asserted after COMPLETE re-raises irq_o 1 cycle later.
- ENABLE cleared on a pending source: irq_o drops next cycle and PENDING is retained.
- Writes with wb_sel_i ≠ 4'hF give err and no state change. Reads ignore wb_sel_i.
- Nested claims are allowed: several sources can be in service at once, each removed from arbitration independently.

Test Plan:
- Reset: rst_n=0 for 2 cycles with irq_src_i=8'hFF and ENABLE pre-written → after release all registers read 0, irq_o=0, no ack during reset.
- Edge latch: write EDGE=8'h01, ENABLE=8'h01; pulse irq_src_i[0] for 1 cycle → PENDING=8'h01; irq_o=1 two edges after the rising edge; irq_id_o=0.
- Priority + claim: edge sources 2 and 5 pending and enabled → CLAIM returns 32'h8000_0002 and irq_id_o becomes 5. A second CLAIM returns 32'h8000_0005 and irq_o then falls. A third CLAIM returns 32'h0000_0000.
- Complete/level: level source 3 held high, ENABLE=8'h08 → CLAIM returns 32'h8000_0003 and irq_o=0. COMPLETE write 3 → irq_o=1 again next cycle. Drop the source, then COMPLETE → irq_o=0.
- W1C collision: edge source 1 pending; W1C PENDING=8'h02 in the same cycle as a new rising edge on src 1 → PENDING[1] stays 1.
- Bus errors: read 0x18 → err=1, ack=0; write ENABLE with wb_sel_i=4'h3 → err, ENABLE unchanged. COMPLETE id 31 with NUM_SRC=8 → ack, no state change.

Source files
------------

// File: rtl/wb_irq_ctrl.sv
// wb_irq_ctrl
// Wishbone-slave interrupt controller. It captures the raw interrupt sources
// as edge or level events and masks them with ENABLE. Sources that software
// has claimed are held out of arbitration until they are completed. The
// lowest-index request wins and drives one registered irq line.
//
// Ports
//   clk, rst_n           system clock, synchronous active-low reset
//   irq_src_i[NUM_SRC]   raw interrupt sources, synchronous to clk
//   wb_adr_i[AW]         byte address, only [4:2] decoded
//   wb_dat_i[DW]         write data
//   wb_sel_i[4]          byte selects, writes need all four
//   wb_we_i/stb_i/cyc_i  Wishbone control
//   wb_dat_o[DW]         read data, loaded on every accepted transfer
//   wb_ack_o, wb_err_o   one-cycle response pulse, exactly one per transfer
//   wb_rty_o             always 0
//   irq_o                interrupt request to the cpu
//   irq_id_o[5]          index of the winning request, valid when irq_o=1
//
// Register map (word offsets)
//   0x00 STATUS    RO  PENDING & ENABLE & ~INSERV
//   0x04 PENDING   R   write-1-to-clear, edge sources only
//   0x08 ENABLE    RW
//   0x0C EDGE      RW  1 = rising-edge source, 0 = level source
//   0x10 CLAIM     R   {valid[31], id[4:0]}, claims the winner
//   0x14 COMPLETE  W   id[4:0], releases that source
//   0x18, 0x1C     unmapped, respond with err
//
// Bus FSM
//   state   | meaning
//   IDLE    | waiting for cyc & stb, accepts and registers the response
//   RESP    | ack/err is on the bus for this one cycle, strobe ignored
//
// DW must be at least 32 because the CLAIM valid flag sits at bit 31.

module wb_irq_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int DW      = 32,
  parameter int AW      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic [AW-1:0]      wb_adr_i,
  input  logic [DW-1:0]      wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  output logic [DW-1:0]      wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  output logic               irq_o,
  output logic [4:0]         irq_id_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  localparam logic [2:0] A_STATUS   = 3'd0;
  localparam logic [2:0] A_PENDING  = 3'd1;
  localparam logic [2:0] A_ENABLE   = 3'd2;
  localparam logic [2:0] A_EDGE     = 3'd3;
  localparam logic [2:0] A_CLAIM    = 3'd4;
  localparam logic [2:0] A_COMPLETE = 3'd5;

  localparam logic [NUM_SRC-1:0] SRC_ONE = NUM_SRC'(1);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_edge;
  logic [NUM_SRC-1:0] r_inserv;
  logic [NUM_SRC-1:0] r_src_q;

  logic [DW-1:0]      r_dat;
  logic               r_ack;
  logic               r_err;
  logic               r_irq;
  logic [4:0]         r_irq_id;

  logic               w_accept;
  logic [2:0]         w_adr;
  logic               w_sel_full;
  logic               w_bad;
  logic               w_wr;
  logic               w_rd;

  logic [NUM_SRC-1:0] w_req;
  logic [4:0]         w_winner;
  logic               w_any;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_w1c_mask;
  logic [NUM_SRC-1:0] w_claim_mask;
  logic [NUM_SRC-1:0] w_cmpl_mask;
  logic [NUM_SRC-1:0] w_pending_nxt;
  logic [DW-1:0]      w_rdata;
  logic               w_unused;

  // Address bits outside [4:2] and data bits above the implemented sources
  // carry no meaning here.
  assign w_unused = ^{wb_adr_i, wb_dat_i};

  // ---------------------------------------------------------------- bus FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------------- decode
  assign w_adr      = wb_adr_i[4:2];
  assign w_sel_full = (wb_sel_i == 4'hF);
  // Partial writes and the two unmapped words answer with err and do nothing.
  assign w_bad      = (w_adr > A_COMPLETE) || (wb_we_i && !w_sel_full);
  assign w_wr       = w_accept && wb_we_i && !w_bad;
  assign w_rd       = w_accept && !wb_we_i && !w_bad;

  // ------------------------------------------------------------ arbitration
  assign w_req = r_pending & r_enable & ~r_inserv;
  assign w_any = |w_req;

  // Scanning downward leaves the lowest set index as the winner.
  always_comb begin
    w_winner = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_winner = 5'(i);
      end
    end
  end

  // --------------------------------------------------------- source capture
  assign w_rise = irq_src_i & ~r_src_q;

  assign w_w1c_mask = (w_wr && (w_adr == A_PENDING)) ? wb_dat_i[NUM_SRC-1:0] : '0;

  // The claim uses the request vector as registered before this edge, so a
  // source rising in the same cycle cannot be claimed until the next one.
  assign w_claim_mask = (w_rd && (w_adr == A_CLAIM) && w_any) ?
                        (SRC_ONE << w_winner) : '0;

  assign w_cmpl_mask = (w_wr && (w_adr == A_COMPLETE) &&
                        (32'(wb_dat_i[4:0]) < NUM_SRC)) ?
                       (SRC_ONE << wb_dat_i[4:0]) : '0;

  // Edge sources: a new rising edge beats any clear in the same cycle, so an
  // event arriving during a W1C or claim is never lost. Level sources simply
  // follow the input.
  assign w_pending_nxt = (r_edge & (w_rise | (r_pending & ~(w_w1c_mask | w_claim_mask)))) |
                         (~r_edge & irq_src_i);

  // --------------------------------------------------------- register file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_enable  <= '0;
      r_edge    <= '0;
      r_inserv  <= '0;
      r_src_q   <= '0;
    end else begin
      r_src_q   <= irq_src_i;
      r_pending <= w_pending_nxt;
      r_inserv  <= (r_inserv | w_claim_mask) & ~w_cmpl_mask;
      if (w_wr && (w_adr == A_ENABLE)) begin
        r_enable <= wb_dat_i[NUM_SRC-1:0];
      end
      if (w_wr && (w_adr == A_EDGE)) begin
        r_edge <= wb_dat_i[NUM_SRC-1:0];
      end
    end
  end

  // --------------------------------------------------------------- read mux
  always_comb begin
    w_rdata = '0;
    case (w_adr)
      A_STATUS:  w_rdata[NUM_SRC-1:0] = w_req;
      A_PENDING: w_rdata[NUM_SRC-1:0] = r_pending;
      A_ENABLE:  w_rdata[NUM_SRC-1:0] = r_enable;
      A_EDGE:    w_rdata[NUM_SRC-1:0] = r_edge;
      A_CLAIM: begin
        if (w_any) begin
          w_rdata[31]  = 1'b1;
          w_rdata[4:0] = w_winner;
        end
      end
      default: w_rdata = '0;
    endcase
  end

  // ------------------------------------------------------ registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dat    <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_irq    <= 1'b0;
      r_irq_id <= 5'd0;
    end else begin
      r_ack    <= w_accept && !w_bad;
      r_err    <= w_accept && w_bad;
      // Writes and errors return zero; read data holds until the next transfer.
      if (w_accept) begin
        r_dat <= w_rd ? w_rdata : '0;
      end
      r_irq    <= w_any;
      r_irq_id <= w_winner;
    end
  end

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_rty_o = 1'b0;
  assign irq_o    = r_irq;
  assign irq_id_o = r_irq_id;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
module tb_wb_irq_ctrl;

  localparam int NS = 8;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] src;
  logic [31:0]   wb_adr;
  logic [31:0]   wb_dat;
  logic [3:0]    wb_sel;
  logic          wb_we;
  logic          wb_stb;
  logic          wb_cyc;
  logic [31:0]   dat_o;
  logic          ack;
  logic          err;
  logic          rty;
  logic          irq;
  logic [4:0]    irq_id;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  wb_irq_ctrl #(.NUM_SRC(NS), .DW(32), .AW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_src_i(src),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat),
    .wb_sel_i (wb_sel),
    .wb_we_i  (wb_we),
    .wb_stb_i (wb_stb),
    .wb_cyc_i (wb_cyc),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty),
    .irq_o    (irq),
    .irq_id_o (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------- reference model
  bit          m_pend [NS];
  bit          m_en   [NS];
  bit          m_edge [NS];
  bit          m_ins  [NS];
  bit          m_srcq [NS];
  bit          m_busy;
  logic        e_ack, e_err, e_irq;
  logic [31:0] e_dat;
  logic [4:0]  e_id;

  task automatic model_step();
    int         win;
    int         id;
    bit         acc;
    logic [2:0] a;
    bit         rise  [NS];
    bit         n_pend[NS];
    bit         n_en  [NS];
    bit         n_edge[NS];
    bit         n_ins [NS];
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_ins[i] = 0; m_srcq[i] = 0;
      end
      m_busy = 0;
      e_ack = 0; e_err = 0; e_dat = '0; e_irq = 0; e_id = '0;
      return;
    end
    win = -1;
    for (int i = 0; i < NS; i++)
      if (win < 0 && m_pend[i] && m_en[i] && !m_ins[i]) win = i;
    acc = !m_busy && (wb_cyc === 1'b1) && (wb_stb === 1'b1);
    a   = wb_adr[4:2];
    for (int i = 0; i < NS; i++) begin
      rise[i]   = src[i] && !m_srcq[i];
      n_pend[i] = m_edge[i] ? (m_pend[i] || rise[i]) : src[i];
      n_en[i]   = m_en[i];
      n_edge[i] = m_edge[i];
      n_ins[i]  = m_ins[i];
    end
    e_ack = 0;
    e_err = 0;
    if (acc) begin
      e_dat = '0;
      if (a >= 3'd6 || (wb_we && wb_sel != 4'hF)) begin
        e_err = 1;
      end else begin
        e_ack = 1;
        if (wb_we) begin
          case (a)
            3'd1: for (int i = 0; i < NS; i++)
                    if (wb_dat[i] && m_edge[i] && !rise[i]) n_pend[i] = 0;
            3'd2: for (int i = 0; i < NS; i++) n_en[i] = wb_dat[i];
            3'd3: for (int i = 0; i < NS; i++) n_edge[i] = wb_dat[i];
            3'd5: begin
              id = int'(wb_dat[4:0]);
              if (id < NS) n_ins[id] = 0;
            end
            default: ;
          endcase
        end else begin
          case (a)
            3'd0: for (int i = 0; i < NS; i++) e_dat[i] = m_pend[i] && m_en[i] && !m_ins[i];
            3'd1: for (int i = 0; i < NS; i++) e_dat[i] = m_pend[i];
            3'd2: for (int i = 0; i < NS; i++) e_dat[i] = m_en[i];
            3'd3: for (int i = 0; i < NS; i++) e_dat[i] = m_edge[i];
            3'd4: if (win >= 0) begin
              e_dat = 32'h8000_0000 | 32'(win);
              n_ins[win] = 1;
              if (m_edge[win] && !rise[win]) n_pend[win] = 0;
            end
            default: ;
          endcase
        end
      end
    end
    e_irq = (win >= 0);
    e_id  = (win >= 0) ? 5'(win) : 5'd0;
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = n_pend[i]; m_en[i] = n_en[i]; m_edge[i] = n_edge[i];
      m_ins[i]  = n_ins[i];  m_srcq[i] = src[i];
    end
    m_busy = acc;
  endtask

  always @(posedge clk) model_step();

  // ------------------------------------------------------------- comparisons
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack",  {31'b0, ack}, {31'b0, e_ack});
      chk("err",  {31'b0, err}, {31'b0, e_err});
      chk("rty",  {31'b0, rty}, 32'd0);
      chk("dat",  dat_o, e_dat);
      chk("irq",  {31'b0, irq}, {31'b0, e_irq});
      if (e_irq) chk("irq_id", {27'b0, irq_id}, {27'b0, e_id});
    end
  end

  // ---------------------------------------------------------------- bus tasks
  task automatic bus(input bit we, input logic [7:0] off, input logic [31:0] d,
                     input logic [3:0] sel, output logic [31:0] r,
                     output logic a, output logic e);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = {24'b0, off}; wb_dat = d; wb_sel = sel;
    @(negedge clk);
    r = dat_o; a = ack; e = err;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] r;
    logic a, e;
    bus(1'b1, off, d, 4'hF, r, a, e);
    chk("wr_ack", {31'b0, a}, 32'd1);
  endtask

  task automatic rd(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] r;
    logic a, e;
    bus(1'b0, off, 32'd0, 4'hF, r, a, e);
    chk(name, r, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    chk(name, {31'b0, irq}, {31'b0, exp});
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] r;
    logic a, e;
    rst_n = 1'b0; src = '0;
    wb_adr = '0; wb_dat = '0; wb_sel = 4'hF; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // reset clears everything even with sources high and a strobe pending
    wr(8'h08, 32'hFF);
    wr(8'h0C, 32'h0F);
    @(negedge clk);
    src = 8'hFF; rst_n = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h08; wb_dat = 32'h0;
    @(negedge clk);
    chk("rst_no_ack0", {31'b0, ack}, 32'd0);
    @(negedge clk);
    chk("rst_no_ack1", {31'b0, ack}, 32'd0);
    rst_n = 1'b1; src = '0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    rd("rst_status",  8'h00, 32'h0);
    rd("rst_pending", 8'h04, 32'h0);
    rd("rst_enable",  8'h08, 32'h0);
    rd("rst_edge",    8'h0C, 32'h0);
    rd("rst_claim",   8'h10, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // edge latch and two-edge latency
    wr(8'h0C, 32'h01);
    wr(8'h08, 32'h01);
    @(negedge clk); src[0] = 1'b1;
    @(negedge clk); chk_irq("edge_irq_1edge", 1'b0); src[0] = 1'b0;
    @(negedge clk); chk_irq("edge_irq_2edge", 1'b1);
    chk("edge_id", {27'b0, irq_id}, 32'd0);
    rd("edge_pending", 8'h04, 32'h01);
    wr(8'h04, 32'h01);
    rd("edge_w1c", 8'h04, 32'h00);

    // priority and nested claims
    wr(8'h0C, 32'h24);
    wr(8'h08, 32'h24);
    @(negedge clk); src = 8'h24;
    @(negedge clk); src = 8'h00;
    @(negedge clk);
    chk_irq("prio_irq", 1'b1);
    chk("prio_id2", {27'b0, irq_id}, 32'd2);
    rd("claim_2", 8'h10, 32'h8000_0002);
    @(negedge clk);
    chk("prio_id5", {27'b0, irq_id}, 32'd5);
    rd("claim_5", 8'h10, 32'h8000_0005);
    @(negedge clk);
    chk_irq("prio_irq_fall", 1'b0);
    rd("claim_none", 8'h10, 32'h0);
    wr(8'h14, 32'd2);
    wr(8'h14, 32'd5);

    // level source with complete
    wr(8'h0C, 32'h00);
    wr(8'h08, 32'h08);
    @(negedge clk); src = 8'h08;
    @(negedge clk);
    @(negedge clk);
    chk("lvl_id", {27'b0, irq_id}, 32'd3);
    rd("claim_3", 8'h10, 32'h8000_0003);
    @(negedge clk);
    chk_irq("lvl_inserv", 1'b0);
    wr(8'h14, 32'd3);
    @(negedge clk);
    chk_irq("lvl_reraise", 1'b1);
    rd("claim_3b", 8'h10, 32'h8000_0003);
    src = 8'h00;
    wr(8'h14, 32'd3);
    @(negedge clk);
    @(negedge clk);
    chk_irq("lvl_dropped", 1'b0);

    // W1C colliding with a new edge: the edge wins
    wr(8'h0C, 32'h02);
    wr(8'h08, 32'h02);
    @(negedge clk); src[1] = 1'b1;
    @(negedge clk); src[1] = 1'b0;
    @(negedge clk);
    src[1] = 1'b1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h04; wb_dat = 32'h02; wb_sel = 4'hF;
    @(negedge clk);
    chk("w1c_coll_ack", {31'b0, ack}, 32'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; src[1] = 1'b0;
    rd("w1c_coll_pend", 8'h04, 32'h02);
    wr(8'h04, 32'h02);
    rd("w1c_plain", 8'h04, 32'h00);

    // bus errors and out-of-range bits
    bus(1'b0, 8'h18, 32'h0, 4'hF, r, a, e);
    chk("unmapped_err", {30'b0, e, a}, 32'd2);
    bus(1'b0, 8'h1C, 32'h0, 4'h0, r, a, e);
    chk("unmapped_err2", {30'b0, e, a}, 32'd2);
    wr(8'h08, 32'hFFFF_FFFF);
    rd("en_width", 8'h08, 32'h0000_00FF);
    wr(8'h08, 32'h5A);
    bus(1'b1, 8'h08, 32'hFF, 4'h3, r, a, e);
    chk("partial_err", {30'b0, e, a}, 32'd2);
    rd("partial_noeff", 8'h08, 32'h5A);
    wr(8'h0C, 32'h00);
    @(negedge clk); src = 8'h10;
    @(negedge clk);
    rd("claim_4", 8'h10, 32'h8000_0004);
    bus(1'b1, 8'h14, 32'd31, 4'hF, r, a, e);
    chk("cmpl31_ack", {30'b0, e, a}, 32'd1);
    rd("cmpl31_status", 8'h00, 32'h00);
    wr(8'h14, 32'd4);
    rd("cmpl4_status", 8'h00, 32'h10);
    src = 8'h00;

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) src = src ^ 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) begin
        wb_cyc = 1'b1; wb_stb = 1'b1;
        wb_we  = 1'($urandom_range(0, 1));
        wb_adr = $urandom;
        wb_sel = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        wb_dat = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 31));
      end else begin
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      end
    end
    @(negedge clk);
    rst_n = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; src = '0;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
